// File: rtl/twiddle_pair_sequencer.sv
// Issues cos/sin requests per angle to sine_calculator and pairs results into a FIFO.
// Optional TWIDDLE_CONJ_EN inverts the stored sine sign bit (conjugate twiddles).
module twiddle_pair_sequencer #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23,
    parameter int CALC_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [EXP_LEN+MANTISSA_LEN:0] in_theta,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0] calc_theta,
    output logic                          calc_enable,
    output logic                          calc_sine_cosine,
    input  logic [EXP_LEN+MANTISSA_LEN:0] calc_value,
    output logic [EXP_LEN+MANTISSA_LEN:0] out_cos,
    output logic [EXP_LEN+MANTISSA_LEN:0] out_sin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);
    localparam int W  = EXP_LEN + MANTISSA_LEN + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int L  = CALC_LATENCY;

    typedef enum logic [1:0] {S_IDLE, S_COS, S_SIN} state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_calc_en;
    logic            r_calc_sc;
    logic [W-1:0]    r_theta;
    logic [W-1:0]    r_cos_hold;
    logic [CW-1:0]   r_credits;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [W-1:0]    r_mem_cos [FIFO_DEPTH];
    logic [W-1:0]    r_mem_sin [FIFO_DEPTH];
    logic [L-1:0]    r_tag_v;
    logic [L-1:0]    r_tag_sc;

    logic            w_hs;
    logic            w_pop;
    logic            w_push;
    logic            w_cap;
    logic            w_room;
    logic [CW-1:0]   w_credits_nx;
    logic [W-1:0]    w_sin_push;

    assign w_hs         = in_valid && r_in_ready;
    assign w_pop        = (r_count != '0) && out_ready;
    assign w_push       = r_tag_v[L-1] && r_tag_sc[L-1];
    assign w_cap        = r_tag_v[L-1] && !r_tag_sc[L-1];
    assign w_credits_nx = r_credits + CW'(w_hs) - CW'(w_pop);
    assign w_room       = w_credits_nx < CW'(FIFO_DEPTH);

`ifdef TWIDDLE_CONJ_EN
    assign w_sin_push = {~calc_value[W-1], calc_value[W-2:0]};
`else
    assign w_sin_push = calc_value;
`endif

    // in_ready is registered from the next state and next credit count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_calc_en  <= 1'b0;
            r_calc_sc  <= 1'b0;
            r_theta    <= '0;
            r_credits  <= '0;
        end else begin
            r_credits <= w_credits_nx;
            if (w_hs)
                r_theta <= in_theta;
            unique case (r_state)
                S_IDLE, S_SIN: begin
                    r_state    <= w_hs ? S_COS : S_IDLE;
                    r_calc_en  <= w_hs;
                    r_calc_sc  <= 1'b0;
                    r_in_ready <= !w_hs && w_room;
                end
                S_COS: begin
                    r_state    <= S_SIN;
                    r_calc_en  <= 1'b1;
                    r_calc_sc  <= 1'b1;
                    r_in_ready <= w_room;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_calc_en  <= 1'b0;
                    r_calc_sc  <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v  <= '0;
            r_tag_sc <= '0;
        end else begin
            for (int i = L - 1; i > 0; i--) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_sc[i] <= r_tag_sc[i-1];
            end
            r_tag_v[0]  <= r_calc_en;
            r_tag_sc[0] <= r_calc_sc;
        end
    end

    // credits guarantee a push never finds the FIFO full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cos_hold <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_cos[i] <= '0;
                r_mem_sin[i] <= '0;
            end
        end else begin
            if (w_cap)
                r_cos_hold <= calc_value;
            if (w_push) begin
                r_mem_cos[r_wr] <= r_cos_hold;
                r_mem_sin[r_wr] <= w_sin_push;
                r_wr            <= r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign in_ready         = r_in_ready;
    assign calc_theta       = r_theta;
    assign calc_enable      = r_calc_en;
    assign calc_sine_cosine = r_calc_sc;
    assign out_cos          = r_mem_cos[r_rd];
    assign out_sin          = r_mem_sin[r_rd];
    assign out_valid        = r_count != '0;
    assign busy             = (r_state != S_IDLE) || (|r_tag_v) || (r_count != '0);

endmodule

// File: tb/tb_twiddle_pair_sequencer.sv
// Directed bench for twiddle_pair_sequencer with a latency-L calculator model
// and a scoreboard of expected {cos, sin} pairs.
module tb_twiddle_pair_sequencer;
    localparam int L = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_theta = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] calc_theta;
    logic        calc_enable;
    logic        calc_sine_cosine;
    logic [31:0] calc_value;
    logic [31:0] out_cos;
    logic [31:0] out_sin;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    twiddle_pair_sequencer #(
        .EXP_LEN(8), .MANTISSA_LEN(23), .CALC_LATENCY(L), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .in_theta(in_theta), .in_valid(in_valid), .in_ready(in_ready),
        .calc_theta(calc_theta), .calc_enable(calc_enable),
        .calc_sine_cosine(calc_sine_cosine), .calc_value(calc_value),
        .out_cos(out_cos), .out_sin(out_sin), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] th, input logic sc);
        if (th == 32'h3F000000)
            return sc ? 32'h3EF57744 : 32'h3F60A8C4;
        return th ^ (sc ? 32'h0055AA00 : 32'h00AA0055);
    endfunction

    function automatic logic [31:0] mk(input int n);
        if (n == 0)
            return 32'h3F000000;
        return 32'h3E800000 + 32'(n) * 32'h00012345;
    endfunction

    // calculator model: keeps running through reset so stale results reach the DUT
    logic [31:0] mp [L];
    always @(posedge clk) begin
        mp[0] <= calc_enable ? model(calc_theta, calc_sine_cosine) : 32'h0BADF00D;
        for (int i = 1; i < L; i++)
            mp[i] <= mp[i-1];
    end
    assign calc_value = mp[L-1];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sent = 0;
    int feed_n = 0;
    int ang_ctr = 0;
    int npops = 0;
    int pop_first = 0;
    int pop_last = 0;
    int en_run = 0;
    int max_run = 0;
    logic [63:0] q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        hs;
        logic [63:0] e;
        logic [31:0] s;
        hs = in_valid && in_ready;
        if (calc_enable === 1'b1) begin
            en_run++;
            if (en_run > max_run)
                max_run = en_run;
        end else begin
            en_run = 0;
        end
        if (out_valid && out_ready) begin
            chk("pop_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pair_cos", out_cos, e[63:32]);
                chk("pair_sin", out_sin, e[31:0]);
            end
            if (npops == 0)
                pop_first = cyc;
            pop_last = cyc;
            npops++;
        end
        if (hs) begin
            s = model(in_theta, 1'b1);
`ifdef TWIDDLE_CONJ_EN
            s[31] = ~s[31];
`endif
            q.push_back({model(in_theta, 1'b0), s});
            sent++;
            ang_ctr++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            in_valid = (sent < feed_n);
            in_theta = mk(ang_ctr);
        end
    endtask

    task automatic start_feed(input int n);
        sent = 0;
        feed_n = n;
        npops = 0;
        in_theta = mk(ang_ctr);
        in_valid = (n > 0);
    endtask

    initial begin
        // reset and idle
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_calc_en", calc_enable, 0);
        chk("rst_calc_sc", calc_sine_cosine, 0);
        chk("rst_calc_theta", calc_theta, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_cos", out_cos, 0);
        chk("rst_out_sin", out_sin, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        chk("rdy_deassert_cycle", in_ready, 0);
        tick();
        chk("rdy_after_rst", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_out_valid", out_valid, 0);
            chk("idle_calc_en", calc_enable, 0);
        end
        chk("idle_in_ready", in_ready, 1);

        // single angle, timing per cycle
        out_ready = 1'b1;
        start_feed(1);
        tick();
        chk("c1_en", calc_enable, 1);
        chk("c1_sc", calc_sine_cosine, 0);
        chk("c1_theta", calc_theta, 32'h3F000000);
        tick();
        chk("c2_en", calc_enable, 1);
        chk("c2_sc", calc_sine_cosine, 1);
        tick();
        chk("c3_en", calc_enable, 0);
        tick();
        chk("c4_out_valid", out_valid, 0);
        tick();
        chk("c5_out_valid", out_valid, 1);
        chk("c5_out_cos", out_cos, 32'h3F60A8C4);
`ifdef TWIDDLE_CONJ_EN
        chk("c5_out_sin_conj", out_sin, 32'hBEF57744);
`else
        chk("c5_out_sin", out_sin, 32'h3EF57744);
`endif
        tick();
        chk("single_pops", npops, 1);
        chk("single_drained", out_valid, 0);

        // back-to-back stream of 8
        for (int i = 0; i < 3; i++) tick();
        max_run = 0;
        start_feed(8);
        for (int k = 0; k < 80 && (sent < 8 || q.size() != 0); k++) tick();
        chk("b2b_sent", sent, 8);
        chk("b2b_q_empty", q.size(), 0);
        chk("b2b_en_run", max_run, 16);
        chk("b2b_pops", npops, 8);
        chk("b2b_spacing", pop_last - pop_first, 14);

        // backpressure
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        start_feed(6);
        for (int i = 0; i < 20; i++) tick();
        chk("bp_accepted", sent, D);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_ready_after_pop", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 80 && (sent < 6 || q.size() != 0); k++) tick();
        chk("bp_sent", sent, 6);
        chk("bp_q_empty", q.size(), 0);
        chk("bp_pops", npops, 6);

        // reset the cycle after the sine request
        for (int i = 0; i < 4; i++) tick();
        start_feed(1);
        tick();
        tick();
        chk("rr_sin_issued", calc_sine_cosine, 1);
        tick();
        rst = 1'b1;
        q.delete();
        tick();
        chk("rr_in_ready", in_ready, 0);
        chk("rr_calc_en", calc_enable, 0);
        chk("rr_calc_theta", calc_theta, 0);
        chk("rr_out_valid", out_valid, 0);
        chk("rr_out_cos", out_cos, 0);
        chk("rr_out_sin", out_sin, 0);
        chk("rr_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rr_stale_ignored", out_valid, 0);
        chk("rr_stale_busy", busy, 0);
        start_feed(1);
        for (int k = 0; k < 40 && (sent < 1 || q.size() != 0); k++) tick();
        chk("rr_recover_q", q.size(), 0);
        chk("rr_recover_pops", npops, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/twiddle_pair_sequencer.md
# twiddle_pair_sequencer

Sits directly upstream and downstream of `sine_calculator` in the twiddle-factor path. It accepts a stream of IEEE-754 angles and issues two requests per angle to the calculator: cosine first, then sine. It tags each request in flight and pairs the two returned values into one complex twiddle `{cos, sin}`. Pairs are buffered in an output FIFO with valid/ready, and a credit scheme guarantees that no in-flight result is ever dropped.

## Interface
Parameters:
- `EXP_LEN`, default 8: float exponent width.
- `MANTISSA_LEN`, default 23: float mantissa width. Word width W = EXP_LEN+MANTISSA_LEN+1.
- `CALC_LATENCY`, default 2: cycles from a calculator request edge to the matching `calc_value`. Must be ≥1.
- `FIFO_DEPTH`, default 4: output FIFO entries. Must be a power of 2 and ≥2.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_theta` input W: angle.
- `in_valid` input 1: angle valid.
- `in_ready` output 1: angle accepted on `in_valid && in_ready`.
- `calc_theta` output W: drives the calculator's `inp_theta`.
- `calc_enable` output 1: drives the calculator's `enable`.
- `calc_sine_cosine` output 1: drives `inp_sine_cosine`; 0 = cosine, 1 = sine.
- `calc_value` input W: the calculator's `out_value`.
- `out_cos` output W: FIFO head, cosine.
- `out_sin` output W: FIFO head, sine.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: pop on `out_valid && out_ready`.
- `busy` output 1: high if the FSM is not in IDLE, any tag is in flight, or the FIFO is non-empty.

## Operation
- FSM states: IDLE, ISSUE_COS, ISSUE_SIN.
- IDLE:
  - Goes to ISSUE_COS on an input handshake.
  - The handshake latches `in_theta` into `theta_q`.
- ISSUE_COS:
  - Drives `calc_enable=1`, `calc_sine_cosine=0`.
  - Always goes to ISSUE_SIN.
- ISSUE_SIN:
  - Drives `calc_enable=1`, `calc_sine_cosine=1`.
  - Goes to ISSUE_COS on a handshake in the same cycle (back-to-back); otherwise goes to IDLE.
- `calc_theta` always equals `theta_q`. `calc_enable=0` and `calc_sine_cosine=0` in IDLE.
- `in_ready = (state==IDLE || state==ISSUE_SIN) && credits < FIFO_DEPTH`. Both terms come from registered state.
- Credits:
  - `credits` = FIFO occupancy + pairs accepted but not yet pushed.
  - +1 on an input handshake; −1 on a pop.
  - Both in the same cycle leaves it unchanged.
  - A pop does not raise `in_ready` until the next cycle.
- Tag pipe:
  - A CALC_LATENCY-deep shift register of `{valid, sc}`.
  - Loaded with `{calc_enable, calc_sine_cosine}` each cycle.
  - The tail qualifies `calc_value`.
- Pairing:
  - A tail tag `{1,0}` captures `calc_value` into `cos_hold`.
  - A tail tag `{1,1}` pushes `{cos_hold, calc_value}` into the FIFO.
  - Values are passed bit-exact; no arithmetic.
- FIFO:
  - Show-ahead; `out_cos`/`out_sin` present the head.
  - Credits guarantee no push when full. Simultaneous push and pop is legal at any occupancy.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pop when empty is ignored.
- Reset:
  - Returns the FSM to IDLE and clears the tag pipe, FIFO, credits and `cos_hold`.
  - Calculator results still in flight when reset deasserts carry invalid tags and are discarded.

## Timing
- Reset values: `in_ready=0`, `calc_enable=0`, `calc_sine_cosine=0`, `calc_theta=0`, `out_valid=0`, `out_cos=0`, `out_sin=0`, `busy=0`.
- `in_ready` rises the cycle after `rst` deasserts.
- Latency:
  - Handshake at edge 0; cosine issued in cycle 1, sine in cycle 2.
  - Results return in cycles 1+L and 2+L (L = CALC_LATENCY); the pair is pushed at the end of cycle 2+L.
  - `out_valid` is high in cycle 3+L (cycle 5 for L=2).
- Throughput: one pair per 2 cycles while `out_ready=1` and credits allow.

## Configuration
- `TWIDDLE_CONJ_EN`:
  - Defined: the sign bit (MSB) of the sine word is inverted on push, so the FIFO holds conjugate twiddles for the inverse transform.
  - Undefined: the sine word is stored unmodified.
- Cosine is never altered.

## Test plan
- Reset, then idle: `in_ready` is 1 from the cycle after reset, `out_valid` stays 0, and `calc_enable` stays 0.
- Single angle `0x3F000000` (calculator model returns `0x3F60A8C4` for cosine, `0x3EF57744` for sine, L=2): `calc_enable` is high in cycles 1–2 with `calc_sine_cosine` 0 then 1, and `out_valid` is high in cycle 5 with `out_cos=0x3F60A8C4`, `out_sin=0x3EF57744`.
- Back-to-back stream of 8 angles with `out_ready=1`: `calc_enable` stays high continuously for 16 cycles, and 8 pairs emerge in input order, one every 2 cycles.
- Backpressure (`out_ready=0`, `FIFO_DEPTH=4`, 6 angles offered): exactly 4 are accepted, then `in_ready` drops. After one pop, `in_ready` returns the following cycle; no pair is lost or duplicated.
- Reset asserted the cycle after the sine request: all outputs return to their reset values, stale `calc_value` returns are ignored, and the next angle produces a correct pair.
- With `TWIDDLE_CONJ_EN` defined, sine `0x3EF57744` emerges as `0xBEF57744` and cosine is unchanged.
